// File: rtl/draw_pkg.sv
// Shared types and constants for the draw scheduler and its command FIFO.
package draw_pkg;

  localparam int unsigned N_ENG    = 3;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned DIAM_W   = 8;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  typedef enum logic [1:0] {
    ENG_FILL     = 2'd0,
    ENG_CIRCLE   = 2'd1,
    ENG_REULEAUX = 2'd2,
    ENG_BAD      = 2'd3
  } eng_id_t;

  typedef struct packed {
    eng_id_t             eng;
    logic [COL_W-1:0]    colour;
    logic [X_W-1:0]      cx;
    logic [Y_W-1:0]      cy;
    logic [DIAM_W-1:0]   diam;
  } draw_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RELEASE
  } sched_state_t;

  // One-hot engine select; the illegal id selects nothing.
  function automatic logic [N_ENG-1:0] eng_onehot(input eng_id_t id);
    logic [N_ENG-1:0] oh;
    oh = '0;
    case (id)
      ENG_FILL:     oh = 3'b001;
      ENG_CIRCLE:   oh = 3'b010;
      ENG_REULEAUX: oh = 3'b100;
      default:      oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Command FIFO for the draw scheduler; DEPTH must be a power of two >= 2.
module draw_cmd_fifo
  import draw_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  draw_cmd_t din,
  output draw_cmd_t dout,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  draw_cmd_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;
  logic            wr_en;
  logic            rd_en;

  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;
  assign count_n = count + CW'(wr_en) - CW'(rd_en);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally; full/empty are registered decodes of the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/draw_scheduler.sv
// Queues host draw commands and runs the shape engines one at a time on a shared VGA port.
// Optional DRAW_SCHED_PIXCNT_EN adds a saturating per-command plotted-pixel counter.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_eng,
  input  logic [COL_W-1:0]        cmd_colour,
  input  logic [X_W-1:0]          cmd_cx,
  input  logic [Y_W-1:0]          cmd_cy,
  input  logic [DIAM_W-1:0]       cmd_diam,
  output logic [N_ENG-1:0]        eng_start,
  input  logic [N_ENG-1:0]        eng_done,
  output logic [COL_W-1:0]        eng_colour,
  output logic [X_W-1:0]          eng_cx,
  output logic [Y_W-1:0]          eng_cy,
  output logic [DIAM_W-1:0]       eng_diam,
  input  logic [N_ENG*X_W-1:0]    eng_vga_x,
  input  logic [N_ENG*Y_W-1:0]    eng_vga_y,
  input  logic [N_ENG*COL_W-1:0]  eng_vga_colour,
  input  logic [N_ENG-1:0]        eng_vga_plot,
  output logic [X_W-1:0]          vga_x,
  output logic [Y_W-1:0]          vga_y,
  output logic [COL_W-1:0]        vga_colour,
  output logic                    vga_plot,
  output logic                    busy,
  output logic                    err_badcmd
`ifdef DRAW_SCHED_PIXCNT_EN
  ,
  output logic [15:0]             pix_count
`endif
);

  sched_state_t       state;
  draw_cmd_t          fifo_din;
  draw_cmd_t          fifo_dout;
  draw_cmd_t          cmd_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [N_ENG-1:0]   act;
  logic               done_act_c;
  logic               plot_c;

  assign fifo_din   = '{eng: eng_id_t'(cmd_eng), colour: cmd_colour, cx: cmd_cx,
                        cy: cmd_cy, diam: cmd_diam};
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign done_act_c = |(eng_done & act);

  draw_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer: start stays high until done, then waits for done to drop before the next command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      act        <= '0;
      eng_start  <= '0;
      eng_colour <= '0;
      eng_cx     <= '0;
      eng_cy     <= '0;
      eng_diam   <= '0;
      err_badcmd <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state != S_IDLE) || !fifo_empty;
      case (state)
        S_IDLE: begin
          if (pop) begin
            cmd_q <= fifo_dout;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          eng_colour <= cmd_q.colour;
          eng_cx     <= cmd_q.cx;
          eng_cy     <= cmd_q.cy;
          eng_diam   <= cmd_q.diam;
          act        <= eng_onehot(cmd_q.eng);
          if (cmd_q.eng == ENG_BAD) begin
            err_badcmd <= 1'b1;
            state      <= S_IDLE;
          end else begin
            eng_start <= eng_onehot(cmd_q.eng);
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (done_act_c) begin
            eng_start <= '0;
            state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!done_act_c) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pixel mux from the active engine, clipped to the visible screen.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    plot_c     = 1'b0;
    if (state == S_RUN || state == S_RELEASE) begin
      for (int unsigned i = 0; i < N_ENG; i++) begin
        if (act[i]) begin
          vga_x      = eng_vga_x[i*X_W +: X_W];
          vga_y      = eng_vga_y[i*Y_W +: Y_W];
          vga_colour = eng_vga_colour[i*COL_W +: COL_W];
          plot_c     = eng_vga_plot[i];
        end
      end
    end
    vga_plot = plot_c && (vga_x < X_W'(SCREEN_W)) && (vga_y < Y_W'(SCREEN_H));
  end

`ifdef DRAW_SCHED_PIXCNT_EN
  // Plotted-pixel count for the most recent command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_count <= '0;
    end else if (state == S_LOAD) begin
      pix_count <= '0;
    end else if (vga_plot && (pix_count != 16'hFFFF)) begin
      pix_count <= pix_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler with behavioural shape-engine models.
module tb_draw_scheduler;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [1:0] eng;
    logic [2:0] colour;
    logic [7:0] cx;
    logic [6:0] cy;
    logic [7:0] diam;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_eng;
  logic [2:0]  cmd_colour;
  logic [7:0]  cmd_cx;
  logic [6:0]  cmd_cy;
  logic [7:0]  cmd_diam;
  logic [2:0]  eng_start;
  logic [2:0]  eng_done;
  logic [2:0]  eng_colour;
  logic [7:0]  eng_cx;
  logic [6:0]  eng_cy;
  logic [7:0]  eng_diam;
  logic [23:0] eng_vga_x;
  logic [20:0] eng_vga_y;
  logic [8:0]  eng_vga_colour;
  logic [2:0]  eng_vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        err_badcmd;
`ifdef DRAW_SCHED_PIXCNT_EN
  logic [15:0] pix_count;
`endif

  logic [7:0]  px [3];
  logic [6:0]  py [3];
  logic [2:0]  pc [3];
  logic [2:0]  pp;
  logic [2:0]  done_x;
  logic [2:0]  done_m;
  int          eng_lat [3];
  int          cnt [3];

  exp_t        sb [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          rises = 0;
  logic [2:0]  prev_start = '0;
  logic [2:0]  rise_v;
  exp_t        mon_e;

  always #5 clk = ~clk;

  draw_scheduler #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_eng        (cmd_eng),
    .cmd_colour     (cmd_colour),
    .cmd_cx         (cmd_cx),
    .cmd_cy         (cmd_cy),
    .cmd_diam       (cmd_diam),
    .eng_start      (eng_start),
    .eng_done       (eng_done),
    .eng_colour     (eng_colour),
    .eng_cx         (eng_cx),
    .eng_cy         (eng_cy),
    .eng_diam       (eng_diam),
    .eng_vga_x      (eng_vga_x),
    .eng_vga_y      (eng_vga_y),
    .eng_vga_colour (eng_vga_colour),
    .eng_vga_plot   (eng_vga_plot),
    .vga_x          (vga_x),
    .vga_y          (vga_y),
    .vga_colour     (vga_colour),
    .vga_plot       (vga_plot),
    .busy           (busy),
    .err_badcmd     (err_badcmd)
`ifdef DRAW_SCHED_PIXCNT_EN
    ,
    .pix_count      (pix_count)
`endif
  );

  assign eng_vga_x      = {px[2], px[1], px[0]};
  assign eng_vga_y      = {py[2], py[1], py[0]};
  assign eng_vga_colour = {pc[2], pc[1], pc[0]};
  assign eng_vga_plot   = pp;
  assign eng_done       = done_m | done_x;

  // Engine model: done rises eng_lat cycles after start, drops the cycle after start falls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_m <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!eng_start[i]) begin
          done_m[i] <= 1'b0;
          cnt[i]    <= 0;
        end else if (!done_m[i]) begin
          cnt[i] <= cnt[i] + 1;
          if (cnt[i] + 1 >= eng_lat[i]) done_m[i] <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Start-rise monitor: each new start must match the next queued command.
  always @(negedge clk) begin
    rise_v     = eng_start & ~prev_start;
    prev_start = eng_start;
    if (rise_v != 3'b000) begin
      rises++;
      check("start_done_clear", 32'(eng_done), 32'd0);
      if (sb.size() == 0) begin
        check("sb_unexpected_start", 32'(eng_start), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_start", 32'(eng_start), 32'(3'b001 << mon_e.eng));
        check("sb_colour", 32'(eng_colour), 32'(mon_e.colour));
        check("sb_cx", 32'(eng_cx), 32'(mon_e.cx));
        check("sb_cy", 32'(eng_cy), 32'(mon_e.cy));
        check("sb_diam", 32'(eng_diam), 32'(mon_e.diam));
      end
    end
  end

  task automatic send(input logic [1:0] e, input logic [2:0] c, input logic [7:0] x,
                      input logic [6:0] y, input logic [7:0] d, output int waits);
    cmd_valid  = 1'b1;
    cmd_eng    = e;
    cmd_colour = c;
    cmd_cx     = x;
    cmd_cy     = y;
    cmd_diam   = d;
    waits      = 0;
    @(negedge clk);
    while (!cmd_ready && waits < 500) begin
      @(negedge clk);
      waits++;
    end
    check("accept_in_time", 32'(waits < 500), 32'd1);
    if (e != 2'd3) sb.push_back('{eng: e, colour: c, cx: x, cy: y, diam: d});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    repeat (3) @(negedge clk);
    while ((busy || sb.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check(tag, 32'(w < 3000), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input int i);
    int w;
    w = 0;
    @(negedge clk);
    while (!eng_start[i] && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("start_seen", 32'(w < 500), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    int r0;
    cmd_valid = 1'b0; cmd_eng = '0; cmd_colour = '0; cmd_cx = '0; cmd_cy = '0; cmd_diam = '0;
    pp = '0; done_x = '0;
    for (int i = 0; i < 3; i++) begin
      px[i] = '0; py[i] = '0; pc[i] = '0; eng_lat[i] = 5;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_start", 32'(eng_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_badcmd), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_cx", 32'(eng_cx), 32'd0);
    @(posedge clk);
    #1;

    // Single circle: latency, hold and release timing.
    eng_lat[1] = 50;
    send(2'd1, 3'b010, 8'd80, 7'd60, 8'd20, w);
    @(negedge clk); check("lat_t1", 32'(eng_start), 32'd0);
    @(negedge clk); check("lat_t2", 32'(eng_start), 32'd0);
    check("load_plot", 32'(vga_plot), 32'd0);
    @(negedge clk); check("lat_t3", 32'(eng_start), 32'b010);
    check("busy_run", 32'(busy), 32'd1);
    w = 0;
    while (!eng_done[1] && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", 32'(w < 200), 32'd1);
    check("start_held", 32'(eng_start), 32'b010);
    check("param_stable", 32'(eng_cx), 32'd80);
    @(negedge clk); check("start_released", 32'(eng_start), 32'd0);
    @(negedge clk); check("busy_release", 32'(busy), 32'd1);
    @(negedge clk); check("busy_lag", 32'(busy), 32'd1);
    @(negedge clk); check("busy_fall", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back commands queued behind a running draw.
    eng_lat[0] = 5; eng_lat[1] = 8; eng_lat[2] = 6;
    r0 = rises;
    send(2'd1, 3'd1, 8'd10, 7'd11, 8'd12, w);
    send(2'd0, 3'd4, 8'd0, 7'd0, 8'd0, w);   check("ready_b2b_fill", 32'(w), 32'd0);
    send(2'd1, 3'd5, 8'd33, 7'd44, 8'd55, w); check("ready_b2b_circle", 32'(w), 32'd0);
    send(2'd2, 3'd6, 8'd150, 7'd100, 8'd9, w); check("ready_b2b_reul", 32'(w), 32'd0);
    wait_idle("b2b_idle");
    check("b2b_rises", 32'(rises - r0), 32'd4);

    // Fill the FIFO behind an in-flight draw; the fifth push waits for a pop.
    eng_lat[0] = 3; eng_lat[1] = 3; eng_lat[2] = 40;
    r0 = rises;
    send(2'd2, 3'd7, 8'd1, 7'd2, 8'd3, w);
    wait_rise(2);
    @(posedge clk);
    #1;
    send(2'd0, 3'd1, 8'd4, 7'd5, 8'd6, w);    check("fifo_accept0", 32'(w), 32'd0);
    send(2'd1, 3'd2, 8'd7, 7'd8, 8'd9, w);    check("fifo_accept1", 32'(w), 32'd0);
    send(2'd0, 3'd3, 8'd10, 7'd11, 8'd12, w); check("fifo_accept2", 32'(w), 32'd0);
    send(2'd1, 3'd4, 8'd13, 7'd14, 8'd15, w); check("fifo_accept3", 32'(w), 32'd0);
    cmd_valid = 1'b1; cmd_eng = 2'd2; cmd_colour = 3'd5;
    cmd_cx = 8'd99; cmd_cy = 7'd88; cmd_diam = 8'd77;
    @(negedge clk); check("ready_full", 32'(cmd_ready), 32'd0);
    w = 0;
    while (!eng_done[2] && w < 200) begin
      @(negedge clk);
      w++;
    end
    while (eng_done[2] && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("full_done_cycle", 32'(w < 400), 32'd1);
    @(negedge clk); check("ready_pop_cycle", 32'(cmd_ready), 32'd0);
    @(negedge clk); check("ready_after_pop", 32'(cmd_ready), 32'd1);
    eng_lat[2] = 4;
    sb.push_back('{eng: 2'd2, colour: 3'd5, cx: 8'd99, cy: 7'd88, diam: 8'd77});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle("full_idle");
    check("full_rises", 32'(rises - r0), 32'd6);

    // Illegal id is skipped with a sticky error; the next command runs.
    r0 = rises;
    check("err_before_bad", 32'(err_badcmd), 32'd0);
    send(2'd3, 3'd7, 8'd200, 7'd127, 8'd255, w);
    send(2'd2, 3'd2, 8'd70, 7'd50, 8'd30, w);
    wait_idle("bad_idle");
    check("err_set", 32'(err_badcmd), 32'd1);
    check("bad_rises", 32'(rises - r0), 32'd1);

    // Mux, screen clipping and a stray done from an inactive engine.
    eng_lat[1] = 20;
    pp[0] = 1'b1; px[0] = 8'd5; py[0] = 7'd5; pc[0] = 3'd7;
    send(2'd1, 3'd3, 8'd80, 7'd60, 8'd40, w);
    wait_rise(1);
    @(posedge clk);
    #1 pp[1] = 1'b1; px[1] = 8'd159; py[1] = 7'd119; pc[1] = 3'd3;
    @(negedge clk);
    check("mux_plot_edge", 32'(vga_plot), 32'd1);
    check("mux_x_edge", 32'(vga_x), 32'd159);
    check("mux_y_edge", 32'(vga_y), 32'd119);
    check("mux_col_edge", 32'(vga_colour), 32'd3);
    @(posedge clk);
    #1 px[1] = 8'd160; py[1] = 7'd10;
    @(negedge clk);
    check("mux_plot_clip", 32'(vga_plot), 32'd0);
    check("mux_x_clip", 32'(vga_x), 32'd160);
    @(posedge clk);
    #1 pp[1] = 1'b0; px[1] = 8'd20; py[1] = 7'd20; pc[1] = 3'd1; done_x[0] = 1'b1;
    @(negedge clk);
    check("mux_plot_inactive", 32'(vga_plot), 32'd0);
    check("mux_x_active", 32'(vga_x), 32'd20);
    check("mux_col_active", 32'(vga_colour), 32'd1);
    @(posedge clk);
    #1 done_x[0] = 1'b0;
    @(negedge clk);
    check("stray_done_ignored", 32'(eng_start), 32'b010);
    @(posedge clk);
    #1;
    wait_idle("mux_idle");
    @(negedge clk);
    check("idle_plot", 32'(vga_plot), 32'd0);
    check("idle_x", 32'(vga_x), 32'd0);
    check("err_sticky", 32'(err_badcmd), 32'd1);
`ifdef DRAW_SCHED_PIXCNT_EN
    check("pix_count_cmd", 32'(pix_count), 32'd1);
`endif
    @(posedge clk);
    #1 pp[0] = 1'b0;

    // Asynchronous reset in the middle of a draw with a command still queued.
    eng_lat[1] = 30;
    send(2'd1, 3'd4, 8'd40, 7'd40, 8'd10, w);
    send(2'd0, 3'd2, 8'd0, 7'd0, 8'd0, w);
    wait_rise(1);
    @(posedge clk);
    #1 pp[1] = 1'b1; px[1] = 8'd10; py[1] = 7'd10;
    @(negedge clk);
    check("pre_rst_plot", 32'(vga_plot), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_start", 32'(eng_start), 32'd0);
    check("rst_async_plot", 32'(vga_plot), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    sb.delete();
    pp = '0;
    r0 = rises;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_start", 32'(eng_start), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_err", 32'(err_badcmd), 32'd0);
    check("post_rst_no_rise", 32'(rises - r0), 32'd0);
`ifdef DRAW_SCHED_PIXCNT_EN
    check("post_rst_pix", 32'(pix_count), 32'd0);
`endif
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
